// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge APB sequencer.
// Holds the FSM state encoding, default bus widths and reset values of the
// registered APB/AHB outputs.
package bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } apb_state_t;

  // Reset values of the registered outputs (addresses/data/selects reset to 0).
  localparam apb_state_t RST_STATE     = ST_IDLE;
  localparam logic       RST_PENABLE   = 1'b0;
  localparam logic       RST_PWRITE    = 1'b0;
  localparam logic       RST_HREADYOUT = 1'b1;

  // States whose entry edge launches an APB write SETUP phase.
  function automatic logic is_write_setup(apb_state_t s);
    return (s == ST_WRITE) || (s == ST_WRITEP);
  endfunction

  // States whose entry edge launches an APB ENABLE (access) phase.
  function automatic logic is_enable(apb_state_t s);
    return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
  endfunction

endpackage

// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB slave interface, the APB sequencer and the APB
// slaves: accepted-transfer qualifier, pipelined address/data, select decode,
// APB master signals and the AHB ready/read-data return path.
interface apb_fsm_controller_if
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
);
  // AHB slave-interface side
  logic              valid;
  logic              hwrite;
  logic              hwritereg;
  logic [ADDR_W-1:0] haddr;
  logic [ADDR_W-1:0] haddr1;
  logic [ADDR_W-1:0] haddr2;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hwdata1;
  logic [SEL_W-1:0]  tempselx;
  logic              hreadyout;
  logic [DATA_W-1:0] hrdata;
  // APB side
  logic [DATA_W-1:0] prdata;
  logic [SEL_W-1:0]  pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;

  // Sequencer view: drives the APB master signals and the AHB ready/rdata.
  modport master (
    input  valid, hwrite, hwritereg, haddr, haddr1, haddr2,
    input  hwdata, hwdata1, tempselx, prdata,
    output pselx, penable, pwrite, paddr, pwdata, hreadyout, hrdata
  );

  // Surrounding logic view: AHB slave interface plus APB slaves.
  modport slave (
    output valid, hwrite, hwritereg, haddr, haddr1, haddr2,
    output hwdata, hwdata1, tempselx, prdata,
    input  pselx, penable, pwrite, paddr, pwdata, hreadyout, hrdata
  );

endinterface

// File: rtl/apb_fsm_controller.sv
// Purpose: sequences APB SETUP/ENABLE phases for transfers accepted by the AHB slave interface.
// Latency: read SETUP 1 cycle after valid, write SETUP 2 cycles after valid; ENABLE 1 cycle later.
// Backpressure: drops hreadyout during every SETUP cycle to stall the AHB master; no APB pready.
module apb_fsm_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic                 hclk,
  input  logic                 hreset,
  apb_fsm_controller_if.master bus
);

  apb_state_t        r_state;
  apb_state_t        w_next_state;

  logic [SEL_W-1:0]  r_sel_d1;
  logic [SEL_W-1:0]  r_sel_d2;

  logic [SEL_W-1:0]  r_pselx;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_hreadyout;

  // Write SETUP taken straight out of WWAIT with no transfer pending: the
  // write's address is one stage old and its data is on the bus right now.
  // Every other write SETUP works from the two-stage-old address.
  logic              w_fresh_write;

  assign w_fresh_write = (r_state == ST_WWAIT) && (w_next_state == ST_WRITE);

  // State register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Select decode delayed to line up with haddr1/haddr2.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_sel_d1 <= '0;
      r_sel_d2 <= '0;
    end else begin
      r_sel_d1 <= bus.tempselx;
      r_sel_d2 <= r_sel_d1;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.valid && bus.hwrite) begin
          w_next_state = ST_WWAIT;
        end else if (bus.valid) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WWAIT:  w_next_state = bus.valid ? ST_WRITEP : ST_WRITE;
      ST_READ:   w_next_state = ST_RENABLE;
      ST_WRITE:  w_next_state = bus.valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP: w_next_state = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (bus.valid && !bus.hwrite) begin
          w_next_state = ST_READ;
        end else if (bus.valid) begin
          w_next_state = ST_WWAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WENABLEP: begin
        // hwritereg tells us the direction of the transfer queued behind this write.
        if (!bus.hwritereg) begin
          w_next_state = ST_READ;
        end else if (bus.valid) begin
          w_next_state = ST_WRITEP;
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // APB/AHB outputs loaded on the edge that enters the next state; unlisted fields hold.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_pselx     <= '0;
      r_penable   <= RST_PENABLE;
      r_pwrite    <= RST_PWRITE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_hreadyout <= RST_HREADYOUT;
    end else if (is_write_setup(w_next_state)) begin
      r_pwrite    <= 1'b1;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b0;
      if (w_fresh_write) begin
        r_pselx  <= r_sel_d1;
        r_paddr  <= bus.haddr1;
        r_pwdata <= bus.hwdata;
      end else begin
        r_pselx  <= r_sel_d2;
        r_paddr  <= bus.haddr2;
        r_pwdata <= bus.hwdata1;
      end
    end else if (is_enable(w_next_state)) begin
      r_penable   <= 1'b1;
      r_hreadyout <= 1'b1;
    end else if (w_next_state == ST_READ) begin
      r_pselx     <= bus.tempselx;
      r_paddr     <= bus.haddr;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b0;
    end else begin
      // ST_IDLE / ST_WWAIT: bus parked, AHB side free to proceed.
      r_pselx     <= '0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b1;
    end
  end

  assign bus.pselx     = r_pselx;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.hreadyout = r_hreadyout;
  assign bus.hrdata    = bus.prdata;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: per-cycle vector table (AHB master behaviour
// already folded in, including stalls while hreadyout is low) plus
// hand-written sequences for async reset during a read and recovery.
module tb_apb_fsm_controller;

  logic hclk;
  logic hreset;

  apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) bus ();

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave-interface model: address decode and one/two-cycle delay lines.
  function automatic logic [2:0] decode_sel(input logic [31:0] a);
    case (a[31:26])
      6'b100000: return 3'b001;   // 0x8000_0000 - 0x83FF_FFFF
      6'b100001: return 3'b010;   // 0x8400_0000 - 0x87FF_FFFF
      6'b100010: return 3'b100;   // 0x8800_0000 - 0x8BFF_FFFF
      default:   return 3'b000;
    endcase
  endfunction

  assign bus.tempselx = decode_sel(bus.haddr);

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      bus.haddr1    <= '0;
      bus.haddr2    <= '0;
      bus.hwdata1   <= '0;
      bus.hwritereg <= 1'b0;
    end else begin
      bus.haddr1    <= bus.haddr;
      bus.haddr2    <= bus.haddr1;
      bus.hwdata1   <= bus.hwdata;
      bus.hwritereg <= bus.hwrite;
    end
  end

  // One cycle of stimulus and the outputs expected during that same cycle.
  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  e_sel;
    logic        e_pen;
    logic        e_pw;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic        e_hr;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic        pen;
    logic        pw;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hr;
    logic [31:0] hrdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic v, input logic w, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [2:0] e_sel, input logic e_pen, input logic e_pw,
                              input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                              input logic e_hr);
    vec_t r;
    r.v = v; r.w = w; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
    r.e_sel = e_sel; r.e_pen = e_pen; r.e_pw = e_pw;
    r.e_paddr = e_paddr; r.e_pwdata = e_pwdata; r.e_hr = e_hr;
    return r;
  endfunction

  task automatic chk(input string tag, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h, expected %h", tag, f, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t r);
    exp_t e;
    e.sel = r.e_sel; e.pen = r.e_pen; e.pw = r.e_pw;
    e.paddr = r.e_paddr; e.pwdata = r.e_pwdata; e.hr = r.e_hr;
    e.hrdata = bus.prdata;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "pselx",     32'(bus.pselx),     32'(e.sel));
      chk(tag, "penable",   32'(bus.penable),   32'(e.pen));
      chk(tag, "pwrite",    32'(bus.pwrite),    32'(e.pw));
      chk(tag, "paddr",     bus.paddr,          e.paddr);
      chk(tag, "pwdata",    bus.pwdata,         e.pwdata);
      chk(tag, "hreadyout", 32'(bus.hreadyout), 32'(e.hr));
      chk(tag, "hrdata",    bus.hrdata,         e.hrdata);
    end
  endtask

  task automatic drive(input vec_t r);
    bus.valid  = r.v;
    bus.hwrite = r.w;
    bus.haddr  = r.addr;
    bus.hwdata = r.wdata;
    bus.prdata = r.rdata;
  endtask

  // Drive a row just after the rising edge, check mid-cycle on the falling edge.
  task automatic run_row(input vec_t r, input string tag);
    @(posedge hclk);
    #1;
    drive(r);
    push_exp(r);
    @(negedge hclk);
    check_now(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] A  = 32'h8000_0010;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] B  = 32'h8400_0004;
  localparam logic [31:0] C  = 32'h8000_0000;
  localparam logic [31:0] D  = 32'h8000_0004;
  localparam logic [31:0] F  = 32'h8800_0000;
  localparam logic [31:0] G  = 32'h8000_0008;
  localparam logic [31:0] H  = 32'h8400_0010;
  localparam logic [31:0] I  = 32'h8400_0020;
  localparam logic [31:0] X  = 32'h9000_0000;

  initial begin
    vec_t r;
    int   prev_pen;

    hreset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    push_exp(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
    check_now("reset");
    hreset = 1'b0;

    //             v  w  addr   wdata  rdata           sel  pen pw paddr  pwdata hr
    // idle after reset
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  0, 0,     0,     1));
    // single write A / DEADBEEF
    vecs.push_back(mk(1, 1, A,     0,     0,            0,   0,  0, 0,     0,     1));
    vecs.push_back(mk(0, 0, 0,     DB,    0,            0,   0,  0, 0,     0,     1));
    vecs.push_back(mk(0, 0, 0,     DB,    0,            1,   0,  1, A,     DB,    0));
    vecs.push_back(mk(0, 0, 0,     0,     0,            1,   1,  1, A,     DB,    1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  1, A,     DB,    1));
    // single read B, prdata 12345678 in the ENABLE cycle
    vecs.push_back(mk(1, 0, B,     0,     0,            0,   0,  1, A,     DB,    1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            2,   0,  0, B,     DB,    0));
    vecs.push_back(mk(0, 0, 0,     0,     32'h12345678, 2,   1,  0, B,     DB,    1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  0, B,     DB,    1));
    // back-to-back writes C/0x11 then D/0x22 (bus parked on C beforehand)
    vecs.push_back(mk(0, 1, C,     32'h11, 0,           0,   0,  0, B,     DB,    1));
    vecs.push_back(mk(1, 1, C,     32'h11, 0,           0,   0,  0, B,     DB,    1));
    vecs.push_back(mk(1, 1, D,     32'h11, 0,           0,   0,  0, B,     DB,    1));
    vecs.push_back(mk(0, 1, D,     32'h22, 0,           1,   0,  1, C,     32'h11, 0));
    vecs.push_back(mk(0, 1, D,     32'h22, 0,           1,   1,  1, C,     32'h11, 1));
    vecs.push_back(mk(0, 1, D,     32'h22, 0,           1,   0,  1, D,     32'h22, 0));
    vecs.push_back(mk(0, 1, D,     32'h22, 0,           1,   1,  1, D,     32'h22, 1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  1, D,     32'h22, 1));
    // write F/0x33 immediately followed by read G
    vecs.push_back(mk(0, 1, F,     32'h33, 0,           0,   0,  1, D,     32'h22, 1));
    vecs.push_back(mk(1, 1, F,     32'h33, 0,           0,   0,  1, D,     32'h22, 1));
    vecs.push_back(mk(1, 0, G,     32'h33, 0,           0,   0,  1, D,     32'h22, 1));
    vecs.push_back(mk(0, 0, G,     32'h33, 0,           4,   0,  1, F,     32'h33, 0));
    vecs.push_back(mk(0, 0, G,     0,     0,            4,   1,  1, F,     32'h33, 1));
    vecs.push_back(mk(0, 0, G,     0,     0,            1,   0,  0, G,     32'h33, 0));
    vecs.push_back(mk(0, 0, 0,     0,     32'hAABBCCDD, 1,   1,  0, G,     32'h33, 1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  0, G,     32'h33, 1));
    // no valid: htrans IDLE / out-of-range address
    vecs.push_back(mk(0, 1, X,     0,     0,            0,   0,  0, G,     32'h33, 1));
    vecs.push_back(mk(0, 0, X,     0,     0,            0,   0,  0, G,     32'h33, 1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  0, G,     32'h33, 1));
    // back-to-back reads H then I (RENABLE -> READ)
    vecs.push_back(mk(1, 0, H,     0,     0,            0,   0,  0, G,     32'h33, 1));
    vecs.push_back(mk(0, 0, I,     0,     0,            2,   0,  0, H,     32'h33, 0));
    vecs.push_back(mk(1, 0, I,     0,     32'h55,       2,   1,  0, H,     32'h33, 1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            2,   0,  0, I,     32'h33, 0));
    vecs.push_back(mk(0, 0, 0,     0,     32'h66,       2,   1,  0, I,     32'h33, 1));
    vecs.push_back(mk(0, 0, 0,     0,     0,            0,   0,  0, I,     32'h33, 1));

    prev_pen = 0;
    foreach (vecs[i]) begin
      run_row(vecs[i], $sformatf("row%0d", i));
      // ENABLE pulses must be separated by at least one non-ENABLE cycle.
      if (vecs[i].e_pen) begin
        n_cmp++;
        if (prev_pen != 0 && bus.penable === 1'b1) begin
          n_bad++;
          $display("FAIL row%0d penable_adjacent: got high twice, required a gap", i);
        end
      end
      prev_pen = int'(bus.penable === 1'b1);
    end

    // Async reset while in the READ SETUP cycle.
    run_row(mk(1, 0, B, 0, 0, 0, 0, 0, I, 32'h33, 1), "rst_pre_idle");
    run_row(mk(0, 0, 0, 0, 0, 2, 0, 0, B, 32'h33, 0), "rst_read_setup");
    #2;
    hreset = 1'b1;
    #1;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push_exp(r);
    check_now("rst_async");
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("post_rst%0d", k));
    end
    // Recovery: a fresh read still works.
    run_row(mk(1, 0, G, 0, 0, 0, 0, 0, 0, 0, 1), "recover_req");
    run_row(mk(0, 0, 0, 0, 0, 1, 0, 0, G, 0, 0), "recover_setup");
    run_row(mk(0, 0, 0, 0, 32'h77, 1, 1, 0, G, 0, 1), "recover_enable");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
